// File: rtl/nib_fifo4.sv
// Synchronous nibble FIFO with registered read data, complement output and occupancy flags.
// Define NIB_FIFO4_ERR_EN to add sticky overflow (OVF) and underflow (UNF) outputs.
module nib_fifo4 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CP,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         D,
    input  logic                     WR,
    input  logic                     RD,
    output logic [WIDTH-1:0]         Q,
    output logic [WIDTH-1:0]         QN,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   CNT
`ifdef NIB_FIFO4_ERR_EN
    ,
    output logic                     OVF,
    output logic                     UNF
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    logic             wr_acc;
    logic             rd_acc;
    logic [AW-1:0]    wr_ptr_nxt;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             empty_nxt;
    logic             full_nxt;

    // A full FIFO still takes a write when a read frees a slot on the same edge;
    // an empty FIFO never lets the incoming word fall through to Q.
    always_comb begin
        wr_acc     = 1'b0;
        rd_acc     = 1'b0;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        cnt_nxt    = cnt;
        empty_nxt  = EMPTY;
        full_nxt   = FULL;

        rd_acc = RD && !EMPTY;
        wr_acc = WR && (!FULL || RD);

        if (wr_acc) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end

        cnt_nxt   = cnt + CW'(wr_acc) - CW'(rd_acc);
        empty_nxt = (cnt_nxt == CW'(0));
        full_nxt  = (cnt_nxt == CW'(DEPTH));
    end

    // Control state: pointers, occupancy and flags, all cleared by reset.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            EMPTY  <= 1'b1;
            FULL   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            cnt    <= cnt_nxt;
            EMPTY  <= empty_nxt;
            FULL   <= full_nxt;
        end
    end

    // Read data register; holds the last word read.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            Q <= '0;
        end else if (rd_acc) begin
            Q <= mem[rd_ptr];
        end
    end

    // Storage is not reset; when full, the write slot equals the read slot and
    // the old word is captured into Q before being overwritten.
    always_ff @(posedge CP) begin
        if (wr_acc) begin
            mem[wr_ptr] <= D;
        end
    end

    assign CNT = cnt;
    assign QN  = ~Q;

`ifdef NIB_FIFO4_ERR_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            OVF <= 1'b0;
            UNF <= 1'b0;
        end else begin
            if (WR && FULL && !RD) begin
                OVF <= 1'b1;
            end
            if (RD && EMPTY) begin
                UNF <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nib_fifo4.sv
// Self-checking bench for nib_fifo4: directed boundary scenarios plus random traffic
// against a queue-based reference model. Honors NIB_FIFO4_ERR_EN.
module tb_nib_fifo4;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             CP;
    logic             RST;
    logic [WIDTH-1:0] D;
    logic             WR;
    logic             RD;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] QN;
    logic             EMPTY;
    logic             FULL;
    logic [CW-1:0]    CNT;
`ifdef NIB_FIFO4_ERR_EN
    logic             OVF;
    logic             UNF;
`endif

    nib_fifo4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CP(CP), .RST(RST), .D(D), .WR(WR), .RD(RD),
        .Q(Q), .QN(QN), .EMPTY(EMPTY), .FULL(FULL), .CNT(CNT)
`ifdef NIB_FIFO4_ERR_EN
        , .OVF(OVF), .UNF(UNF)
`endif
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model state
    logic [WIDTH-1:0] mq_model [$];
    logic [WIDTH-1:0] q_model;
    logic             ovf_model;
    logic             unf_model;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] qn_exp;
        qn_exp = ~q_model;
        check({tag, ".Q"}, Q, q_model);
        check({tag, ".QN"}, QN, qn_exp);
        check({tag, ".CNT"}, CNT, mq_model.size());
        check({tag, ".EMPTY"}, EMPTY, (mq_model.size() == 0) ? 1 : 0);
        check({tag, ".FULL"}, FULL, (mq_model.size() == DEPTH) ? 1 : 0);
`ifdef NIB_FIFO4_ERR_EN
        check({tag, ".OVF"}, OVF, ovf_model);
        check({tag, ".UNF"}, UNF, unf_model);
`endif
    endtask

    // One clock with the given request; model advanced from pre-edge occupancy.
    task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
        int unsigned n;
        WR = wr;
        RD = rd;
        D  = d;
        n  = mq_model.size();
        if (wr && n == DEPTH && !rd) ovf_model = 1'b1;
        if (rd && n == 0) unf_model = 1'b1;
        if (rd && n > 0) q_model = mq_model.pop_front();
        if (wr && (n < DEPTH || rd)) mq_model.push_back(d);
        @(posedge CP);
        #1;
        WR = 1'b0;
        RD = 1'b0;
    endtask

    // Assert reset between edges with live requests; check before and after the edge.
    task automatic do_reset(input string tag);
        RST = 1'b1;
        WR  = 1'b1;
        RD  = 1'b1;
        D   = WIDTH'($urandom);
        mq_model.delete();
        q_model   = '0;
        ovf_model = 1'b0;
        unf_model = 1'b0;
        #1;
        check_all({tag, ".async"});
        @(posedge CP);
        #1;
        check_all({tag, ".held"});
        RST = 1'b0;
        WR  = 1'b0;
        RD  = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        WR  = 1'b0;
        RD  = 1'b0;
        D   = '0;
        #2;
        do_reset("rst0");

        // Basic order
        step(1, 0, 4'h3); step(1, 0, 4'hA); step(1, 0, 4'h5);
        check_all("order.wr");
        step(0, 1, '0); check("order.q0", Q, 4'h3); check("order.qn0", QN, 4'hC);
        step(0, 1, '0); check("order.q1", Q, 4'hA); check("order.qn1", QN, 4'h5);
        step(0, 1, '0); check("order.q2", Q, 4'h5); check("order.qn2", QN, 4'hA);
        check("order.empty", EMPTY, 1);
        check_all("order.end");

        // Fill and overflow
        for (int i = 1; i <= 4; i++) step(1, 0, WIDTH'(i));
        check("fill.full", FULL, 1);
        check("fill.cnt", CNT, 4);
        step(1, 0, 4'hF);
        check("ovf.cnt", CNT, 4);
        check_all("ovf");
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, '0);
            check("ovf.rd", Q, i);
        end
        check_all("ovf.end");

        // Simultaneous access from empty: write taken, no fall-through
        do_reset("rst1");
        step(1, 1, 4'h7);
        check("sim.empty.cnt", CNT, 1);
        check("sim.empty.q", Q, 4'h0);
        check_all("sim.empty");
        step(0, 1, '0);
        check("sim.empty.rd", Q, 4'h7);

        // Simultaneous access from full
        for (int i = 1; i <= 4; i++) step(1, 0, WIDTH'(i));
        step(1, 1, 4'h9);
        check("sim.full.q", Q, 4'h1);
        check("sim.full.full", FULL, 1);
        check_all("sim.full");
        step(0, 1, '0); check("sim.full.r2", Q, 4'h2);
        step(0, 1, '0); check("sim.full.r3", Q, 4'h3);
        step(0, 1, '0); check("sim.full.r4", Q, 4'h4);
        step(0, 1, '0); check("sim.full.r9", Q, 4'h9);
        check_all("sim.full.end");

        // Wrap-around
        for (int i = 0; i < 10; i++) begin
            step(1, 0, WIDTH'(i));
            step(0, 1, '0);
            check("wrap.q", Q, i);
            check("wrap.cnt", CNT, 0);
        end

        // Underflow after reset
        do_reset("rst2");
        step(0, 1, '0);
        check("unf.q", Q, 0);
        check("unf.cnt", CNT, 0);
        check_all("unf");

        // Asynchronous reset mid-operation
        step(1, 0, 4'hB); step(1, 0, 4'hC); step(1, 0, 4'hD);
        step(0, 1, '0);
        step(1, 0, 4'hE);
        check("arst.pre.cnt", CNT, 3);
        do_reset("arst");
        check("arst.cnt", CNT, 0);
        check("arst.empty", EMPTY, 1);
        check("arst.q", Q, 0);
        step(1, 0, 4'h6);
        step(0, 1, '0);
        check("arst.q6", Q, 4'h6);
        check_all("arst.end");

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd.rst");
            end else begin
                step(1'($urandom), 1'($urandom), WIDTH'($urandom));
                check_all("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
